// File: rtl/fetch_branch_unit_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
//   mem_addr  : fetch address (unit -> memory)
//   mem_rd    : read request, held until mem_ready (unit -> memory)
//   mem_rdata : instruction word (memory -> unit)
//   mem_ready : read data valid this cycle (memory -> unit)
interface fetch_branch_unit_if #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned DATA_W = 16
);
  logic [PC_W-1:0]   mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/fetch_branch_unit.sv
// Instruction fetch and branch unit: owns the PC, fetches over a ready/valid
// read bus with a wait-state timeout, and resolves branches from datapath status.
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_fetch_start       : fetch the instruction at pc
//   i_branch_req        : resolve a branch this cycle (mode/cond/status/offset/rd_value)
//   i_halt              : stop after any in-flight fetch
//   bus                 : instruction memory read bus (master side)
//   o_ir, o_ir_valid    : instruction register and its freshness flag
//   o_busy              : state is not idle
//   o_branch_taken      : one-cycle pulse when a branch is applied
//   o_link_we, o_link_pc: one-cycle link write pulse and return address
//   o_fault, o_halted   : sticky timeout fault and halted flags
//   o_fetch_count       : saturating count of completed fetches
module fetch_branch_unit #(
  parameter int unsigned    PC_W     = 8,
  parameter int unsigned    DATA_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned    TIMEOUT  = 15,
  parameter int unsigned    CNT_W    = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_fetch_start,
  input  logic               i_branch_req,
  input  logic [1:0]         i_branch_mode,
  input  logic [2:0]         i_cond,
  input  logic [2:0]         i_status,
  input  logic [DATA_W-1:0]  i_offset,
  input  logic [DATA_W-1:0]  i_rd_value,
  input  logic               i_halt,
  fetch_branch_unit_if.master bus,
  output logic [DATA_W-1:0]  o_ir,
  output logic               o_ir_valid,
  output logic               o_busy,
  output logic               o_branch_taken,
  output logic               o_link_we,
  output logic [PC_W-1:0]    o_link_pc,
  output logic               o_fault,
  output logic               o_halted,
  output logic [CNT_W-1:0]   o_fetch_count
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StFetchWait,
    StHalted
  } state_e;

  state_e            r_state, w_state_next;
  logic [PC_W-1:0]   r_pc, w_pc_next;
  logic [DATA_W-1:0] r_ir, w_ir_next;
  logic              r_ir_valid, w_ir_valid_next;
  logic              r_mem_rd, w_mem_rd_next;
  logic              r_branch_taken, w_branch_taken_next;
  logic              r_link_we, w_link_we_next;
  logic [PC_W-1:0]   r_link_pc, w_link_pc_next;
  logic              r_fault, w_fault_next;
  logic              r_halted, w_halted_next;
  logic [CNT_W-1:0]  r_fetch_count, w_fetch_count_next;
  logic [WaitW-1:0]  r_wait_cnt, w_wait_cnt_next;
  logic              r_halt_seen, w_halt_seen_next;

  logic              w_z, w_n, w_v;
  logic              w_cond_ok;
  logic              w_taken;
  logic [PC_W-1:0]   w_pc_target;
  logic              w_unused_hi;

  // Only the low PC_W bits of offset and rd_value address the program.
  assign w_unused_hi = ^{i_offset[DATA_W-1:PC_W], i_rd_value[DATA_W-1:PC_W]};

  assign w_z = i_status[0];
  assign w_n = i_status[1];
  assign w_v = i_status[2];

  always_comb begin
    w_cond_ok = 1'b0;
    case (i_cond)
      3'b000:  w_cond_ok = 1'b1;
      3'b001:  w_cond_ok = w_z;
      3'b010:  w_cond_ok = ~w_z;
      3'b011:  w_cond_ok = w_n ^ w_v;
      3'b100:  w_cond_ok = (w_n ^ w_v) | w_z;
      default: w_cond_ok = 1'b0;
    endcase
  end

  // Absolute modes are unconditional.
  assign w_taken     = i_branch_mode[1] | w_cond_ok;
  assign w_pc_target = i_branch_mode[1] ? i_rd_value[PC_W-1:0] : r_pc + i_offset[PC_W-1:0];

  always_comb begin
    w_state_next        = r_state;
    w_pc_next           = r_pc;
    w_ir_next           = r_ir;
    w_ir_valid_next     = r_ir_valid;
    w_mem_rd_next       = r_mem_rd;
    w_branch_taken_next = 1'b0;
    w_link_we_next      = 1'b0;
    w_link_pc_next      = r_link_pc;
    w_fault_next        = r_fault;
    w_halted_next       = r_halted;
    w_fetch_count_next  = r_fetch_count;
    w_wait_cnt_next     = r_wait_cnt;
    w_halt_seen_next    = r_halt_seen;

    case (r_state)
      StIdle: begin
        if (i_halt) begin
          w_state_next  = StHalted;
          w_halted_next = 1'b1;
        end else if (i_branch_req) begin
          // A simultaneous fetch_start is dropped; the controller re-asserts it.
          if (w_taken) begin
            w_pc_next           = w_pc_target;
            w_branch_taken_next = 1'b1;
            if (i_branch_mode[0]) begin
              w_link_we_next = 1'b1;
              w_link_pc_next = r_pc;
            end
          end
        end else if (i_fetch_start) begin
          w_state_next     = StFetchWait;
          w_mem_rd_next    = 1'b1;
          w_ir_valid_next  = 1'b0;
          w_wait_cnt_next  = '0;
          w_halt_seen_next = 1'b0;
        end
      end

      StFetchWait: begin
        w_halt_seen_next = r_halt_seen | i_halt;
        if (bus.mem_ready) begin
          w_ir_next       = bus.mem_rdata;
          w_ir_valid_next = 1'b1;
          w_pc_next       = r_pc + PC_W'(1);
          w_mem_rd_next   = 1'b0;
          if (r_fetch_count != '1) begin
            w_fetch_count_next = r_fetch_count + CNT_W'(1);
          end
          if (r_halt_seen | i_halt) begin
            w_state_next  = StHalted;
            w_halted_next = 1'b1;
          end else begin
            w_state_next = StIdle;
          end
        end else if (r_wait_cnt == WaitW'(TIMEOUT - 1)) begin
          // This idle wait cycle is the TIMEOUT-th one: give up, pc and ir untouched.
          w_fault_next  = 1'b1;
          w_mem_rd_next = 1'b0;
          w_state_next  = StHalted;
          w_halted_next = 1'b1;
        end else begin
          w_wait_cnt_next = r_wait_cnt + WaitW'(1);
        end
      end

      StHalted: begin
        w_mem_rd_next = 1'b0;
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_pc           <= RESET_PC;
      r_ir           <= '0;
      r_ir_valid     <= 1'b0;
      r_mem_rd       <= 1'b0;
      r_branch_taken <= 1'b0;
      r_link_we      <= 1'b0;
      r_link_pc      <= '0;
      r_fault        <= 1'b0;
      r_halted       <= 1'b0;
      r_fetch_count  <= '0;
      r_wait_cnt     <= '0;
      r_halt_seen    <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_ir           <= w_ir_next;
      r_ir_valid     <= w_ir_valid_next;
      r_mem_rd       <= w_mem_rd_next;
      r_branch_taken <= w_branch_taken_next;
      r_link_we      <= w_link_we_next;
      r_link_pc      <= w_link_pc_next;
      r_fault        <= w_fault_next;
      r_halted       <= w_halted_next;
      r_fetch_count  <= w_fetch_count_next;
      r_wait_cnt     <= w_wait_cnt_next;
      r_halt_seen    <= w_halt_seen_next;
    end
  end

  assign bus.mem_addr   = r_pc;
  assign bus.mem_rd     = r_mem_rd;
  assign o_ir           = r_ir;
  assign o_ir_valid     = r_ir_valid;
  assign o_busy         = (r_state != StIdle);
  assign o_branch_taken = r_branch_taken;
  assign o_link_we      = r_link_we;
  assign o_link_pc      = r_link_pc;
  assign o_fault        = r_fault;
  assign o_halted       = r_halted;
  assign o_fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Randomised self-checking bench for fetch_branch_unit. A transaction-level
// model (one call per fetch / branch / halt / timeout) predicts the architectural
// state; a second instance with a 2-bit counter shares all stimulus to exercise
// fetch-count saturation.
module tb_fetch_branch_unit;
  localparam int unsigned PC_W    = 8;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_start = 1'b0;
  logic              branch_req = 1'b0;
  logic [1:0]        branch_mode = '0;
  logic [2:0]        cond = '0;
  logic [2:0]        status = '0;
  logic [DATA_W-1:0] offset = '0;
  logic [DATA_W-1:0] rd_value = '0;
  logic              halt = 1'b0;

  logic [DATA_W-1:0] ir, ir2;
  logic              ir_valid, ir_valid2, busy, busy2, taken, taken2, link_we, link_we2;
  logic [PC_W-1:0]   link_pc, link_pc2;
  logic              fault, fault2, halted, halted2;
  logic [15:0]       fcnt;
  logic [1:0]        fcnt2;

  fetch_branch_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W)) u_bus ();
  fetch_branch_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W)) u_bus2 ();

  assign u_bus2.mem_ready = u_bus.mem_ready;
  assign u_bus2.mem_rdata = u_bus.mem_rdata;

  fetch_branch_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .RESET_PC('0), .TIMEOUT(TIMEOUT),
                      .CNT_W(16)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_fetch_start(fetch_start), .i_branch_req(branch_req),
    .i_branch_mode(branch_mode), .i_cond(cond), .i_status(status), .i_offset(offset),
    .i_rd_value(rd_value), .i_halt(halt), .bus(u_bus.master), .o_ir(ir),
    .o_ir_valid(ir_valid), .o_busy(busy), .o_branch_taken(taken), .o_link_we(link_we),
    .o_link_pc(link_pc), .o_fault(fault), .o_halted(halted), .o_fetch_count(fcnt)
  );

  fetch_branch_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .RESET_PC('0), .TIMEOUT(TIMEOUT),
                      .CNT_W(2)) u_dut_sat (
    .i_clk(clk), .i_reset(reset), .i_fetch_start(fetch_start), .i_branch_req(branch_req),
    .i_branch_mode(branch_mode), .i_cond(cond), .i_status(status), .i_offset(offset),
    .i_rd_value(rd_value), .i_halt(halt), .bus(u_bus2.master), .o_ir(ir2),
    .o_ir_valid(ir_valid2), .o_busy(busy2), .o_branch_taken(taken2), .o_link_we(link_we2),
    .o_link_pc(link_pc2), .o_fault(fault2), .o_halted(halted2), .o_fetch_count(fcnt2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model state
  logic [PC_W-1:0]   m_pc;
  logic [DATA_W-1:0] m_ir;
  logic              m_irv;
  logic [PC_W-1:0]   m_link;
  int                m_cnt;
  logic              m_halted;
  logic              m_fault;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cond_true(input logic [2:0] c, input logic [2:0] st);
    bit z, n, v;
    z = st[0];
    n = st[1];
    v = st[2];
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return n != v;
      3'd4:    return (n != v) || z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_state(input string w);
    check_val({w, ".pc"}, 32'(u_bus.mem_addr), 32'(m_pc));
    check_val({w, ".ir"}, 32'(ir), 32'(m_ir));
    check_val({w, ".ir_valid"}, 32'(ir_valid), 32'(m_irv));
    check_val({w, ".link_pc"}, 32'(link_pc), 32'(m_link));
    check_val({w, ".fault"}, 32'(fault), 32'(m_fault));
    check_val({w, ".halted"}, 32'(halted), 32'(m_halted));
    check_val({w, ".fetch_count"}, 32'(fcnt), 32'((m_cnt > 65535) ? 65535 : m_cnt));
    check_val({w, ".fetch_count_sat"}, 32'(fcnt2), 32'((m_cnt > 3) ? 3 : m_cnt));
  endtask

  task automatic model_reset();
    m_pc = '0; m_ir = '0; m_irv = 1'b0; m_link = '0; m_cnt = 0;
    m_halted = 1'b0; m_fault = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_state("reset");
    check_val("reset.mem_rd", 32'(u_bus.mem_rd), 0);
    check_val("reset.busy", 32'(busy), 0);
    check_val("reset.branch_taken", 32'(taken), 0);
    check_val("reset.link_we", 32'(link_we), 0);
  endtask

  task automatic do_branch(input logic [1:0] mode, input logic [2:0] c, input logic [2:0] st,
                           input logic [DATA_W-1:0] off, input logic [DATA_W-1:0] rd,
                           input bit fs);
    bit exp_taken;
    branch_mode = mode; cond = c; status = st; offset = off; rd_value = rd;
    branch_req = 1'b1; fetch_start = fs;
    tick();
    branch_req = 1'b0; fetch_start = 1'b0;
    exp_taken = !m_halted && (mode[1] || cond_true(c, st));
    if (exp_taken) begin
      if (mode[0]) m_link = m_pc;
      m_pc = mode[1] ? rd[PC_W-1:0] : m_pc + off[PC_W-1:0];
    end
    check_val("branch.taken", 32'(taken), 32'(exp_taken));
    check_val("branch.link_we", 32'(link_we), 32'(exp_taken && mode[0]));
    check_val("branch.mem_rd", 32'(u_bus.mem_rd), 0);
    check_state("branch");
    tick();
    check_val("branch.taken_pulse", 32'(taken), 0);
    check_val("branch.link_we_pulse", 32'(link_we), 0);
  endtask

  // lat: idle-ready cycles before ready; halt_at: wait index to raise halt (-1 none)
  task automatic do_fetch(input int lat, input logic [DATA_W-1:0] data, input int halt_at);
    bit hseen;
    hseen = 1'b0;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    if (m_halted) begin
      check_val("fetch_halted.mem_rd", 32'(u_bus.mem_rd), 0);
      check_state("fetch_halted");
      return;
    end
    m_irv = 1'b0;
    check_val("fetch.mem_rd_start", 32'(u_bus.mem_rd), 1);
    check_val("fetch.ir_valid_clr", 32'(ir_valid), 0);
    check_val("fetch.busy", 32'(busy), 1);
    for (int i = 0; i < lat; i++) begin
      halt = (i == halt_at);
      if (halt) hseen = 1'b1;
      // Requests during the wait must be ignored.
      branch_req = 1'($urandom_range(0, 1));
      branch_mode = 2'b10;
      rd_value = DATA_W'($urandom);
      fetch_start = 1'($urandom_range(0, 1));
      tick();
      check_val("fetch.mem_rd_hold", 32'(u_bus.mem_rd), 1);
      check_val("fetch.addr_stable", 32'(u_bus.mem_addr), 32'(m_pc));
    end
    branch_req = 1'b0; fetch_start = 1'b0;
    halt = (halt_at == lat);
    if (halt) hseen = 1'b1;
    u_bus.mem_ready = 1'b1;
    u_bus.mem_rdata = data;
    tick();
    u_bus.mem_ready = 1'b0;
    halt = 1'b0;
    m_ir = data; m_irv = 1'b1; m_pc = m_pc + 1'b1; m_cnt++;
    if (hseen) m_halted = 1'b1;
    check_state("fetch");
    check_val("fetch.mem_rd_drop", 32'(u_bus.mem_rd), 0);
    check_val("fetch.taken", 32'(taken), 0);
  endtask

  task automatic do_halt_idle();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    m_halted = 1'b1;
    check_state("halt_idle");
    check_val("halt_idle.busy", 32'(busy), 1);
  endtask

  task automatic do_timeout();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    m_irv = 1'b0;
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      tick();
      if (k == int'(TIMEOUT) - 1) begin
        check_val("timeout.fault_early", 32'(fault), 0);
        check_val("timeout.mem_rd_early", 32'(u_bus.mem_rd), 1);
      end
    end
    m_fault = 1'b1; m_halted = 1'b1;
    check_state("timeout");
    check_val("timeout.mem_rd", 32'(u_bus.mem_rd), 0);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    check_val("timeout.refetch_mem_rd", 32'(u_bus.mem_rd), 0);
    check_state("timeout_refetch");
  endtask

  task automatic do_reset_mid_fetch();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    tick();
    do_reset();
  endtask

  initial begin
    u_bus.mem_ready = 1'b0;
    u_bus.mem_rdata = '0;
    model_reset();

    // Directed scenarios
    do_reset();
    do_fetch(2, 16'hD105, -1);
    do_branch(2'b10, 3'b000, 3'b000, 16'h0000, 16'h00FE, 1'b0);
    do_branch(2'b00, 3'b001, 3'b001, 16'h0005, 16'h0000, 1'b0);
    check_val("wrap.pc", 32'(u_bus.mem_addr), 32'h03);
    do_branch(2'b10, 3'b000, 3'b000, 16'h0000, 16'h00FE, 1'b0);
    do_branch(2'b00, 3'b010, 3'b001, 16'h0005, 16'h0000, 1'b0);
    check_val("not_taken.pc", 32'(u_bus.mem_addr), 32'hFE);
    do_branch(2'b10, 3'b000, 3'b000, 16'h0000, 16'h0010, 1'b0);
    do_branch(2'b01, 3'b000, 3'b000, 16'hFFFC, 16'h0000, 1'b0);
    check_val("link.pc", 32'(u_bus.mem_addr), 32'h0C);
    check_val("link.link_pc", 32'(link_pc), 32'h10);
    do_branch(2'b10, 3'b111, 3'b000, 16'h0000, 16'h0010, 1'b0);
    do_branch(2'b00, 3'b000, 3'b000, 16'h0003, 16'h0000, 1'b1);
    do_reset_mid_fetch();
    do_timeout();
    do_reset();
    do_fetch(4, 16'hBEEF, 1);
    do_fetch(1, 16'h1234, -1);
    do_branch(2'b11, 3'b000, 3'b000, 16'h0000, 16'h0040, 1'b0);
    do_reset();
    for (int i = 0; i < 5; i++) do_fetch(i, DATA_W'($urandom), -1);
    check_val("sat.fetch_count", 32'(fcnt2), 3);
    check_val("sat.fetch_count_wide", 32'(fcnt), 5);

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int op;
      op = int'($urandom_range(0, 99));
      if (m_halted) begin
        if (op < 50) do_fetch(0, DATA_W'($urandom), -1);
        else do_branch(2'($urandom), 3'($urandom), 3'($urandom), DATA_W'($urandom),
                       DATA_W'($urandom), 1'b0);
        if (op % 3 == 0) do_reset();
      end else if (op < 45) begin
        int lat;
        int hat;
        lat = int'($urandom_range(0, TIMEOUT - 1));
        hat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, lat)) : -1;
        do_fetch(lat, DATA_W'($urandom), hat);
      end else if (op < 93) begin
        do_branch(2'($urandom), 3'($urandom), 3'($urandom), DATA_W'($urandom),
                  DATA_W'($urandom), 1'($urandom));
      end else if (op < 97) begin
        do_halt_idle();
      end else begin
        do_timeout();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_branch_unit.md
Name: fetch_branch_unit

Overview:
- Parametrised instruction fetch and branch unit; next generation of the CPU's program-counter block.
- Owns the PC and fetches instructions over a ready/valid memory read handshake, with a wait-state timeout.
- Resolves conditional, relative, absolute and link branches from datapath status.
- Sits between the controller FSM, the instruction decoder (fed from ir) and instruction memory.

Parameters:
PC_W, 8, program counter and memory address width
DATA_W, 16, instruction, offset and register value width
RESET_PC, 0, PC value loaded on reset
TIMEOUT, 15, max cycles waiting for mem_ready before fault (>=1)
CNT_W, 16, width of retired-fetch counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
fetch_start  input  1  controller request: fetch instruction at PC
branch_req  input  1  controller request: resolve branch this cycle
branch_mode  input  2  00 rel, 01 rel+link, 10 abs (rd_value), 11 abs+link
cond  input  3  branch condition code
status  input  3  {V,N,Z} from datapath
offset  input  DATA_W  sign-extended relative offset (low PC_W bits used)
rd_value  input  DATA_W  absolute target (low PC_W bits used)
halt  input  1  stop after any in-flight fetch
mem_addr  output  PC_W  fetch address (= pc)
mem_rd  output  1  read request, held until mem_ready
mem_rdata  input  DATA_W  instruction word
mem_ready  input  1  read data valid this cycle
ir  output  DATA_W  instruction register
ir_valid  output  1  ir holds a freshly fetched, unconsumed word
busy  output  1  state != IDLE
branch_taken  output  1  one-cycle pulse, branch applied
link_we  output  1  one-cycle pulse, write link_pc to R7
link_pc  output  PC_W  return address (pc before redirect)
fault  output  1  sticky, memory timeout
halted  output  1  sticky, in HALTED
fetch_count  output  CNT_W  saturating count of completed fetches

Behaviour:
- Reset (any state, including mid-fetch):
  - pc=RESET_PC, state=IDLE.
  - ir, ir_valid, mem_rd, branch_taken, link_we, link_pc, fault, halted and fetch_count all 0.
- States: IDLE, FETCH_WAIT, HALTED.
- IDLE, checked in this priority order:
  - halt=1 -> HALTED.
  - Else branch_req=1 -> resolve branch; stay IDLE. fetch_start in the same cycle is ignored and must be reasserted.
  - Else fetch_start=1 -> FETCH_WAIT; mem_rd=1 from the next cycle; ir_valid cleared; wait counter cleared.
- FETCH_WAIT:
  - mem_rd=1; mem_addr=pc stable.
  - On mem_ready=1: ir<=mem_rdata; ir_valid<=1; pc<=pc+1 mod 2^PC_W; fetch_count+1, saturating at all-ones.
  - After mem_ready: HALTED if halt was seen at any point during the fetch, else IDLE.
  - Wait counter increments each cycle mem_ready=0. When it reaches TIMEOUT: fault<=1, mem_rd<=0, go HALTED; pc and ir unchanged.
  - branch_req and fetch_start are ignored in FETCH_WAIT (busy=1).
- Branch condition, Z=status[0], N=status[1], V=status[2]:
  - 000 always; 001 Z; 010 !Z; 011 N!=V; 100 (N!=V)|Z.
  - 101-111 never taken; branch_taken stays 0 and pc is unchanged.
  - Modes 10 and 11 ignore cond (unconditional).
- Taken branch:
  - Relative: pc<=pc+offset[PC_W-1:0], modular, so wrap is legal in both directions.
  - Absolute: pc<=rd_value[PC_W-1:0].
  - branch_taken pulses for 1 cycle.
  - Link modes additionally: link_pc<=pc (already next instruction), link_we pulses for 1 cycle.
- A not-taken branch leaves pc and link_pc unchanged; no pulses.
- HALTED: mem_rd=0; all requests ignored; leaves only on reset.
- Output timing:
  - mem_addr is combinational from pc.
  - All other outputs are registered.
  - busy is decoded from state.

Test Plan:
- Reset, then fetch_start with mem_ready 2 cycles after mem_rd, rdata=16'hD105 -> ir=16'hD105, ir_valid=1, pc=1, fetch_count=1, mem_rd low the cycle after ready.
- pc=8'hFE, status Z=1, branch_req mode 00, cond 001, offset 16'h0005 -> pc=8'h03 (wrap), branch_taken one pulse. Same setup with cond 010 -> pc stays 8'hFE, no pulse.
- pc=8'h10, mode 01, cond 000, offset 16'hFFFC -> pc=8'h0C, link_pc=8'h10, link_we one pulse. Then mode 10, rd_value=16'h0010 -> pc=8'h10, link_we stays 0.
- fetch_start and branch_req asserted together in IDLE -> branch applied, no mem_rd. Later, reset asserted mid-FETCH_WAIT -> all outputs return to reset values next cycle.
- mem_ready held low -> after TIMEOUT=15 wait cycles fault=1, halted=1, mem_rd=0; subsequent fetch_start is ignored.
- halt raised during FETCH_WAIT, ready arrives 3 cycles later -> ir loaded, pc incremented, then halted=1. With CNT_W=2, five fetches -> fetch_count=3 (saturated).
